cpu_boot_ctrl: RTL and testbench

Synthesizable boot and run controller that sits between a program-load stream and the `cpu` core. It holds the core in reset, streams program words into the core's instruction/data memory through a write port, and releases reset after a programmable hold. It then supervises execution with a cycle counter, a halt detector and a watchdog timeout. Software and the bench use it instead of preloading memory with `$readmemb` and a fixed `#` delay.

---
 rtl/cpu_boot_pkg.sv | 25 ++
 rtl/cpu_boot_ctrl_if.sv | 23 ++
 rtl/boot_counter.sv | 22 ++
 rtl/cpu_boot_ctrl.sv | 136 +++++++++++++
 tb/tb_cpu_boot_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_boot_pkg.sv
// Shared types and constants for the CPU boot/run controller.
package cpu_boot_pkg;

  typedef enum logic [2:0] {
    BOOT_IDLE,
    BOOT_LOAD,
    BOOT_HOLD,
    BOOT_RUN,
    BOOT_DONE,
    BOOT_ERR
  } boot_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  // Smallest width that can represent max_val (at least 1 bit).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Program-load stream and memory write port of the boot controller.
interface cpu_boot_ctrl_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 8
);
  logic              ld_valid;
  logic              ld_ready;
  logic [WORD_W-1:0] ld_data;
  logic              ld_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  // master: program source and memory; slave: the boot controller
  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/boot_counter.sv
// Up-counter with synchronous clear, enable and saturation at all-ones.
module boot_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot controller: streams a program into core memory, releases core reset
// after a hold, then supervises the run with a cycle counter and watchdog.
//
// state     | meaning
// BOOT_IDLE | core in reset, waiting for start
// BOOT_LOAD | accepting program words, one memory write per handshake
// BOOT_HOLD | core still in reset while the last write settles
// BOOT_RUN  | core released, cycle counter and watchdog active
// BOOT_DONE | core halted normally, frozen for readout
// BOOT_ERR  | load overflow or watchdog timeout, frozen for readout
module cpu_boot_ctrl
  import cpu_boot_pkg::*;
#(
  parameter int WORD_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int RST_HOLD = 4,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 120
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  cpu_boot_ctrl_if.slave      bus,
  output logic                cpu_rst,
  input  logic                cpu_halt,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [ADDR_W:0]     word_cnt,
  output logic [CNT_W-1:0]    cycle_cnt
);

  localparam int                HOLD_W    = cnt_width(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit                TMO_ON    = (TIMEOUT != 0);

  boot_state_e       state, next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              handshake;
  logic              hold_done;
  logic              timeout_hit;
  logic              load_start;
  logic              cyc_en;

  assign bus.ld_ready = (state == BOOT_LOAD);
  assign handshake    = (state == BOOT_LOAD) && bus.ld_valid;
  assign hold_done    = (state == BOOT_HOLD) && (hold_cnt == HOLD_LAST);
  assign timeout_hit  = TMO_ON && (cycle_cnt == TMO_LAST);
  assign load_start   = start && ((state == BOOT_IDLE) || (state == BOOT_DONE) ||
                                  (state == BOOT_ERR));
  // The release edge already counts, so the first RUN cycle reads 1; a halt
  // freezes the count at the cycle it was reported in.
  assign cyc_en       = hold_done || ((state == BOOT_RUN) && !cpu_halt);

  always_ff @(posedge clk) begin
    if (!rst) state <= BOOT_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      BOOT_IDLE, BOOT_DONE, BOOT_ERR: begin
        if (start) next_state = BOOT_LOAD;
      end
      BOOT_LOAD: begin
        if (handshake) begin
          if (bus.ld_last)                             next_state = BOOT_HOLD;
          else if (word_cnt[ADDR_W-1:0] == ADDR_LAST)  next_state = BOOT_ERR;
        end
      end
      BOOT_HOLD: begin
        if (hold_done) next_state = BOOT_RUN;
      end
      BOOT_RUN: begin
        if (cpu_halt)         next_state = BOOT_DONE;
        else if (timeout_hit) next_state = BOOT_ERR;
      end
      default: next_state = BOOT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      word_cnt      <= '0;
      err_code      <= ERR_NONE;
      cpu_rst       <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      bus.mem_we <= handshake;
      if (handshake) begin
        bus.mem_addr  <= word_cnt[ADDR_W-1:0];
        bus.mem_wdata <= bus.ld_data;
        word_cnt      <= word_cnt + 1'b1;
      end
      if (load_start) begin
        word_cnt <= '0;
        err_code <= ERR_NONE;
      end else if ((state == BOOT_LOAD) && (next_state == BOOT_ERR)) begin
        err_code <= ERR_OVF;
      end else if ((state == BOOT_RUN) && (next_state == BOOT_ERR)) begin
        err_code <= ERR_TMO;
      end
      cpu_rst <= (next_state != BOOT_RUN);
      busy    <= (next_state == BOOT_LOAD) || (next_state == BOOT_HOLD) ||
                 (next_state == BOOT_RUN);
      done    <= (next_state == BOOT_DONE);
      err     <= (next_state == BOOT_ERR);
    end
  end

  boot_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != BOOT_HOLD),
    .en  (state == BOOT_HOLD),
    .cnt (hold_cnt)
  );

  boot_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (load_start),
    .en  (cyc_en),
    .cnt (cycle_cnt)
  );

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl: default instance plus a 3-bit-address
// instance for the load overflow path.
module tb_cpu_boot_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // default-parameter instance
  logic        a_start = 1'b0, a_halt = 1'b0;
  logic        a_cpu_rst, a_busy, a_done, a_err;
  logic [1:0]  a_err_code;
  logic [8:0]  a_word_cnt;
  logic [15:0] a_cycle_cnt;
  cpu_boot_ctrl_if #(.WORD_W(16), .ADDR_W(8)) a_if ();

  cpu_boot_ctrl #(.WORD_W(16), .ADDR_W(8), .RST_HOLD(4), .CNT_W(16), .TIMEOUT(120)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .bus(a_if.slave), .cpu_rst(a_cpu_rst),
    .cpu_halt(a_halt), .busy(a_busy), .done(a_done), .err(a_err),
    .err_code(a_err_code), .word_cnt(a_word_cnt), .cycle_cnt(a_cycle_cnt)
  );

  // small-memory instance
  logic        b_start = 1'b0, b_halt = 1'b0;
  logic        b_cpu_rst, b_busy, b_done, b_err;
  logic [1:0]  b_err_code;
  logic [3:0]  b_word_cnt;
  logic [15:0] b_cycle_cnt;
  cpu_boot_ctrl_if #(.WORD_W(16), .ADDR_W(3)) b_if ();

  cpu_boot_ctrl #(.WORD_W(16), .ADDR_W(3), .RST_HOLD(4), .CNT_W(16), .TIMEOUT(120)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .bus(b_if.slave), .cpu_rst(b_cpu_rst),
    .cpu_halt(b_halt), .busy(b_busy), .done(b_done), .err(b_err),
    .err_code(b_err_code), .word_cnt(b_word_cnt), .cycle_cnt(b_cycle_cnt)
  );

  // bench-side memories fed by the write ports
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [8];
  always @(posedge clk) begin
    if (a_if.mem_we) mem_a[a_if.mem_addr] <= a_if.mem_wdata;
    if (b_if.mem_we) mem_b[b_if.mem_addr] <= b_if.mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, " cpu_rst"},   32'(a_cpu_rst),      32'd1);
    chk({tag, " ld_ready"},  32'(a_if.ld_ready),  32'd0);
    chk({tag, " mem_we"},    32'(a_if.mem_we),    32'd0);
    chk({tag, " mem_addr"},  32'(a_if.mem_addr),  32'd0);
    chk({tag, " mem_wdata"}, 32'(a_if.mem_wdata), 32'd0);
    chk({tag, " busy"},      32'(a_busy),         32'd0);
    chk({tag, " done"},      32'(a_done),         32'd0);
    chk({tag, " err"},       32'(a_err),          32'd0);
    chk({tag, " err_code"},  32'(a_err_code),     32'd0);
    chk({tag, " word_cnt"},  32'(a_word_cnt),     32'd0);
    chk({tag, " cycle_cnt"}, 32'(a_cycle_cnt),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog bench did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic seen;
    a_if.ld_valid = 1'b0; a_if.ld_data = '0; a_if.ld_last = 1'b0;
    b_if.ld_valid = 1'b0; b_if.ld_data = '0; b_if.ld_last = 1'b0;

    // reset values
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk_reset_a("rst");
    chk("rst b cpu_rst", 32'(b_cpu_rst), 32'd1);
    chk("rst b word_cnt", 32'(b_word_cnt), 32'd0);

    // load 5 words, last on the fifth
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("load ld_ready", 32'(a_if.ld_ready), 32'd1);
    chk("load busy", 32'(a_busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      a_if.ld_valid = 1'b1; a_if.ld_data = 16'(i + 1); a_if.ld_last = (i == 4);
      tick();
      chk("load mem_we", 32'(a_if.mem_we), 32'd1);
      chk("load mem_addr", 32'(a_if.mem_addr), 32'(i));
      chk("load mem_wdata", 32'(a_if.mem_wdata), 32'(i + 1));
      chk("load word_cnt", 32'(a_word_cnt), 32'(i + 1));
    end
    a_if.ld_valid = 1'b0; a_if.ld_last = 1'b0;
    chk("hold ld_ready", 32'(a_if.ld_ready), 32'd0);
    repeat (4) tick();
    chk("hold cpu_rst edge4", 32'(a_cpu_rst), 32'd1);
    tick();
    chk("release cpu_rst edge5", 32'(a_cpu_rst), 32'd0);
    chk("release cycle_cnt", 32'(a_cycle_cnt), 32'd1);
    for (int i = 0; i < 5; i++) chk("load mem content", 32'(mem_a[i]), 32'(i + 1));

    // run with ld_valid toggling, halt on cycle 30
    seen = 1'b0;
    for (int c = 1; c < 30; c++) begin
      a_if.ld_valid = (c % 2 == 1);
      tick();
      if (a_if.mem_we || a_if.ld_ready) seen = 1'b1;
    end
    a_if.ld_valid = 1'b0;
    chk("run no write", 32'(seen), 32'd0);
    chk("run cycle30", 32'(a_cycle_cnt), 32'd30);
    a_halt = 1'b1; tick(); a_halt = 1'b0;
    chk("halt done", 32'(a_done), 32'd1);
    chk("halt err", 32'(a_err), 32'd0);
    chk("halt cpu_rst", 32'(a_cpu_rst), 32'd1);
    chk("halt cycle_cnt", 32'(a_cycle_cnt), 32'd30);
    chk("halt busy", 32'(a_busy), 32'd0);
    chk("halt word_cnt", 32'(a_word_cnt), 32'd5);

    // restart from DONE, no halt: watchdog fires
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("tmo restart word_cnt", 32'(a_word_cnt), 32'd0);
    chk("tmo restart cycle_cnt", 32'(a_cycle_cnt), 32'd0);
    chk("tmo restart done", 32'(a_done), 32'd0);
    a_if.ld_valid = 1'b1; a_if.ld_data = 16'h00AA; a_if.ld_last = 1'b1;
    tick();
    a_if.ld_valid = 1'b0; a_if.ld_last = 1'b0;
    repeat (5) tick();
    chk("tmo cycle1", 32'(a_cycle_cnt), 32'd1);
    repeat (118) tick();
    chk("tmo cycle119", 32'(a_cycle_cnt), 32'd119);
    chk("tmo pre err", 32'(a_err), 32'd0);
    tick();
    chk("tmo err", 32'(a_err), 32'd1);
    chk("tmo err_code", 32'(a_err_code), 32'd2);
    chk("tmo cycle_cnt", 32'(a_cycle_cnt), 32'd120);
    chk("tmo done", 32'(a_done), 32'd0);
    chk("tmo cpu_rst", 32'(a_cpu_rst), 32'd1);
    chk("tmo word_cnt", 32'(a_word_cnt), 32'd1);
    chk("tmo mem0", 32'(mem_a[0]), 32'h00AA);
    chk("tmo mem1 kept", 32'(mem_a[1]), 32'd2);

    // restart from ERR, start pulsed in RUN, halt coincides with timeout
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("both restart err_code", 32'(a_err_code), 32'd0);
    chk("both restart err", 32'(a_err), 32'd0);
    a_if.ld_valid = 1'b1; a_if.ld_data = 16'h00BB; a_if.ld_last = 1'b1;
    tick();
    a_if.ld_valid = 1'b0; a_if.ld_last = 1'b0;
    repeat (5) tick();
    repeat (10) tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    repeat (107) tick();
    chk("both cycle119", 32'(a_cycle_cnt), 32'd119);
    a_halt = 1'b1; tick(); a_halt = 1'b0;
    chk("both done", 32'(a_done), 32'd1);
    chk("both err", 32'(a_err), 32'd0);
    chk("both err_code", 32'(a_err_code), 32'd0);
    chk("both cycle_cnt", 32'(a_cycle_cnt), 32'd119);

    // reset in the middle of a load
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_if.ld_valid = 1'b1; a_if.ld_data = 16'h11 * 16'(i + 1); a_if.ld_last = 1'b0;
      tick();
    end
    a_if.ld_valid = 1'b0;
    chk("midload word_cnt", 32'(a_word_cnt), 32'd3);
    rst = 1'b0;
    tick();
    chk_reset_a("midrst");
    rst = 1'b1;
    tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_if.ld_valid = 1'b1; a_if.ld_data = 16'h0044; a_if.ld_last = 1'b1;
    tick();
    a_if.ld_valid = 1'b0; a_if.ld_last = 1'b0;
    chk("reload mem_addr", 32'(a_if.mem_addr), 32'd0);
    chk("reload word_cnt", 32'(a_word_cnt), 32'd1);
    tick();
    chk("reload mem0", 32'(mem_a[0]), 32'h0044);
    chk("reload mem1 kept", 32'(mem_a[1]), 32'h0022);
    chk("reload mem2 kept", 32'(mem_a[2]), 32'h0033);

    // 3-bit address instance: 8 words without last overflows
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b_if.ld_valid = 1'b1; b_if.ld_data = 16'h0100 + 16'(i); b_if.ld_last = 1'b0;
      tick();
      chk("ovf mem_addr", 32'(b_if.mem_addr), 32'(i));
    end
    chk("ovf mem_we", 32'(b_if.mem_we), 32'd1);
    chk("ovf err", 32'(b_err), 32'd1);
    chk("ovf err_code", 32'(b_err_code), 32'd1);
    chk("ovf word_cnt", 32'(b_word_cnt), 32'd8);
    chk("ovf busy", 32'(b_busy), 32'd0);
    chk("ovf ld_ready", 32'(b_if.ld_ready), 32'd0);
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (b_if.mem_we) seen = 1'b1;
    end
    b_if.ld_valid = 1'b0;
    chk("ovf no wrap write", 32'(seen), 32'd0);
    chk("ovf mem0", 32'(mem_b[0]), 32'h0100);
    chk("ovf mem7", 32'(mem_b[7]), 32'h0107);
    chk("ovf word_cnt hold", 32'(b_word_cnt), 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
